fetch_unit: RTL

Instruction fetch stage of MiniMIPS. Holds the program counter and drives the instruction memory's 32-bit word address. It captures the returned 16-bit instruction into the IF/ID pipeline register for the decoder. It handles stalls, control-flow redirects and a halt instruction through a small state machine.

---
 rtl/fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// MiniMIPS instruction fetch stage: owns the PC, drives the word address to
// instruction memory and registers the returned instruction into IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus1;

  assign pc_plus1  = pc + 32'd1;
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= 32'd0;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
      halted        <= 1'b0;
      fetch_count   <= 32'd0;
    end else begin
      case (state)
        // One settling cycle after reset; stall and redirect are ignored here.
        S_BOOT: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect_valid) begin
            pc         <= redirect_target;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr    <= imem_data;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1;
            ifid_valid    <= 1'b1;
            fetch_count   <= fetch_count + 32'd1;
            // The halt word is delivered once, then the PC parks on it.
            if (imem_data == HALT_INSTR) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus1;
            end
          end
        end
        S_HALT: begin
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
          if (redirect_valid) begin
            pc     <= redirect_target;
            state  <= S_FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
